// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op-field width and op codes.
package pc_seq_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_INC    = 3'b000;
  localparam logic [OP_W-1:0] OP_LOAD   = 3'b001;
  localparam logic [OP_W-1:0] OP_BRANCH = 3'b010;
  localparam logic [OP_W-1:0] OP_CALL   = 3'b011;
  localparam logic [OP_W-1:0] OP_RET    = 3'b100;
  localparam logic [OP_W-1:0] OP_HOLD   = 3'b101;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module pc_ras #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 8,
  parameter int CNT_W     = $clog2(RAS_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] top_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);

  logic [WIDTH-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] ptr_inc, ptr_dec;

  // Non-power-of-two depths need explicit wrap of the pointer.
  assign ptr_inc = (wr_ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : PTR_W'(wr_ptr_q + 1'b1);
  assign ptr_dec = (wr_ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : PTR_W'(wr_ptr_q - 1'b1);

  assign top_o   = mem_q[ptr_dec];
  assign full_o  = (count_q == CNT_W'(RAS_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = ptr_inc;
      if (!full_o) count_d = CNT_W'(count_q + 1'b1);
    end else if (pop_i && !empty_o) begin
      wr_ptr_d = ptr_dec;
      count_d  = CNT_W'(count_q - 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push_i && !reset) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-PC selection and sticky stack error flags.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int STEP         = 1,
  parameter int RAS_DEPTH    = 8,
  parameter int RESET_VECTOR = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic [OP_W-1:0]                  op,
  input  logic [WIDTH-1:0]                 target,
  input  logic [WIDTH-1:0]                 offset,
  output logic [WIDTH-1:0]                 pc_out,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             err_overflow,
  output logic                             err_underflow
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic             push, pop;
  logic [WIDTH-1:0] pc_step, ras_top;

  assign pc_step = pc_q + WIDTH'(STEP);

  always_comb begin
    pc_d      = pc_q;
    err_ovf_d = err_ovf_q;
    err_unf_d = err_unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (!stall) begin
      case (op)
        OP_INC:    pc_d = pc_step;
        OP_LOAD:   pc_d = target;
        OP_BRANCH: pc_d = pc_q + offset;
        OP_CALL: begin
          push = 1'b1;
          pc_d = target;
          if (ras_full) err_ovf_d = 1'b1;
        end
        OP_RET: begin
          // An empty stack degrades RET to a plain increment.
          if (ras_empty) begin
            pc_d      = pc_step;
            err_unf_d = 1'b1;
          end else begin
            pop  = 1'b1;
            pc_d = ras_top;
          end
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= WIDTH'(RESET_VECTOR);
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_step),
    .top_o   (ras_top),
    .count_o (ras_count),
    .full_o  (ras_full),
    .empty_o (ras_empty)
  );

  assign pc_out        = pc_q;
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;

endmodule
